// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit ALU.
// The package defines the opcode map, the shifter mode select and the datapath width.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_INC   = 5'h02,
    OP_DEC   = 5'h03,
    OP_AND   = 5'h04,
    OP_OR    = 5'h05,
    OP_XOR   = 5'h06,
    OP_NAND  = 5'h07,
    OP_NOR   = 5'h08,
    OP_XNOR  = 5'h09,
    OP_NOT   = 5'h0A,
    OP_SLL   = 5'h0B,
    OP_SRL   = 5'h0C,
    OP_SRA   = 5'h0D,
    OP_ROL   = 5'h0E,
    OP_ROR   = 5'h0F,
    OP_MUL   = 5'h10,
    OP_SLT   = 5'h11,
    OP_SLTU  = 5'h12,
    OP_EQ    = 5'h13,
    OP_PASSA = 5'h14,
    OP_PASSB = 5'h15,
    OP_NEG   = 5'h16
  } opcode_e;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit.
// The carry output is the last bit shifted out, and it is 0 for rotates or for a zero amount.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [4:0]       amt,
  input  shift_mode_e      mode,
  output logic [ALU_W-1:0] res,
  output logic             carry
);

  // One guard bit on the exit side catches the last bit shifted out.
  logic [ALU_W:0]        sll_x;
  logic [ALU_W:0]        srl_x;
  logic signed [ALU_W:0] sra_x;
  logic [ALU_W-1:0]      rol_x;
  logic [ALU_W-1:0]      ror_x;
  logic [5:0]            inv_amt;

  always_comb begin
    inv_amt = 6'd32 - {1'b0, amt};
    sll_x   = {1'b0, a} << amt;
    srl_x   = {a, 1'b0} >> amt;
    sra_x   = $signed({a, 1'b0}) >>> amt;
    rol_x   = (a << amt) | (a >> inv_amt);
    ror_x   = (a >> amt) | (a << inv_amt);

    res   = '0;
    carry = 1'b0;
    case (mode)
      SH_SLL: begin
        res   = sll_x[ALU_W-1:0];
        carry = sll_x[ALU_W];
      end
      SH_SRL: begin
        res   = srl_x[ALU_W:1];
        carry = srl_x[0];
      end
      SH_SRA: begin
        res   = sra_x[ALU_W:1];
        carry = sra_x[0];
      end
      SH_ROL:  res = rol_x;
      SH_ROR:  res = ror_x;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_design.sv
// 32-bit ALU: a combinational opcode datapath followed by one result register.
// There is no handshake. The inputs are sampled on every rising edge, and the result for those inputs is visible one cycle later.
module alu_design
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [4:0]       opcode,
  output logic [ALU_W-1:0] out,
  output logic             carryout
);

  logic [ALU_W:0]     add_x;
  logic [ALU_W:0]     sub_x;
  logic [ALU_W:0]     inc_x;
  logic [2*ALU_W-1:0] prod;
  logic [ALU_W-1:0]   sh_res;
  logic               sh_carry;
  shift_mode_e        sh_mode;
  logic [ALU_W-1:0]   res;
  logic               cy;

  always_comb begin
    sh_mode = SH_SLL;
    case (opcode_e'(opcode))
      OP_SRL:  sh_mode = SH_SRL;
      OP_SRA:  sh_mode = SH_SRA;
      OP_ROL:  sh_mode = SH_ROL;
      OP_ROR:  sh_mode = SH_ROR;
      default: sh_mode = SH_SLL;
    endcase
  end

  alu_shifter u_shifter (
    .a     (A),
    .amt   (B[4:0]),
    .mode  (sh_mode),
    .res   (sh_res),
    .carry (sh_carry)
  );

  always_comb begin
    add_x = {1'b0, A} + {1'b0, B};
    // SUB is computed as A + ~B + 1, so the carry out means no borrow (A >= B).
    sub_x = {1'b0, A} + {1'b0, ~B} + 33'd1;
    inc_x = {1'b0, A} + 33'd1;
    prod  = {32'b0, A} * {32'b0, B};

    res = '0;
    cy  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD:   {cy, res} = add_x;
      OP_SUB:   {cy, res} = sub_x;
      OP_INC:   {cy, res} = inc_x;
      OP_DEC: begin
        res = A - 32'd1;
        cy  = (A != '0);
      end
      OP_AND:   res = A & B;
      OP_OR:    res = A | B;
      OP_XOR:   res = A ^ B;
      OP_NAND:  res = ~(A & B);
      OP_NOR:   res = ~(A | B);
      OP_XNOR:  res = ~(A ^ B);
      OP_NOT:   res = ~A;
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
        res = sh_res;
        cy  = sh_carry;
      end
      OP_MUL: begin
        res = prod[ALU_W-1:0];
        cy  = |prod[2*ALU_W-1:ALU_W];
      end
      OP_SLT:   res = {31'b0, $signed(A) < $signed(B)};
      OP_SLTU:  res = {31'b0, A < B};
      OP_EQ:    res = {31'b0, A == B};
      OP_PASSA: res = A;
      OP_PASSB: res = B;
      OP_NEG: begin
        res = 32'd0 - A;
        cy  = (A == '0);
      end
      default: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      carryout <= 1'b0;
    end else begin
      out      <= res;
      carryout <= cy;
    end
  end

endmodule

// File: tb/tb_alu_design.sv
// Directed bench for alu_design.
// The driver pushes the hand-computed {carryout,out} for each vector, and the monitor pops and compares one cycle later.
module tb_alu_design;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  opcode;
  logic [31:0] out;
  logic        carryout;

  logic        drv_valid;
  logic [32:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;

  alu_design dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .opcode   (opcode),
    .out      (out),
    .carryout (carryout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: inputs change on the falling edge and are sampled on the next rising edge
  task automatic drive(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eo, input logic ec, input string nm);
    @(negedge clk);
    opcode    = op;
    a         = av;
    b         = bv;
    drv_valid = 1'b1;
    exp_q.push_back({ec, eo});
    name_q.push_back(nm);
  endtask

  task automatic idle();
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    n_checks++;
    if (out !== 32'h0 || carryout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: out=%h cy=%b expected out=00000000 cy=0", nm, out, carryout);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic        v;
    logic [32:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      v = drv_valid;
      #1;
      if (v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: out=%h cy=%b with empty queue", out, carryout);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (out !== e[31:0] || carryout !== e[32]) begin
            n_fail++;
            $display("FAIL %s: out=%h cy=%b expected out=%h cy=%b", nm, out, carryout, e[31:0], e[32]);
          end
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    drv_valid = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("power_on_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // result held just before the mid-run reset
    drive(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, "add_3_4");
    idle();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    drive(OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, "add_wrap");
    drive(OP_SUB,  32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, "sub_5_7");
    drive(OP_SUB,  32'd7, 32'd5, 32'h2, 1'b1, "sub_7_5");
    drive(OP_NEG,  32'd0, 32'd0, 32'h0, 1'b1, "neg_0");
    drive(OP_NEG,  32'd5, 32'd0, 32'hFFFFFFFB, 1'b0, "neg_5");
    drive(OP_INC,  32'hFFFFFFFF, 32'd0, 32'h0, 1'b1, "inc_wrap");
    drive(OP_DEC,  32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, "dec_0");
    drive(OP_DEC,  32'd1, 32'd0, 32'h0, 1'b1, "dec_1");

    drive(OP_SLL,  32'h80000001, 32'd1, 32'h00000002, 1'b1, "sll_1");
    drive(OP_SRA,  32'h80000000, 32'd4, 32'hF8000000, 1'b0, "sra_4");
    drive(OP_SRA,  32'h80000000, 32'h21, 32'hC0000000, 1'b0, "sra_amt_low5");
    drive(OP_SRL,  32'h0000000F, 32'd4, 32'h0, 1'b1, "srl_4");
    drive(OP_SRL,  32'h80000000, 32'd31, 32'h1, 1'b0, "srl_31");
    drive(OP_SLL,  32'h12345678, 32'd0, 32'h12345678, 1'b0, "sll_0");
    drive(OP_SLL,  32'h3, 32'd31, 32'h80000000, 1'b1, "sll_31");
    drive(OP_ROR,  32'h1, 32'd1, 32'h80000000, 1'b0, "ror_1");
    drive(OP_ROL,  32'h80000000, 32'd1, 32'h1, 1'b0, "rol_1");
    drive(OP_ROL,  32'h12345678, 32'd8, 32'h34567812, 1'b0, "rol_8");

    drive(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, "and");
    drive(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, "or");
    drive(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, "xor");
    drive(OP_NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, "nand");
    drive(OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, "nor");
    drive(OP_XNOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0, "xnor");
    drive(OP_NOT,  32'hF0F0F0F0, 32'h0, 32'h0F0F0F0F, 1'b0, "not");
    drive(5'h1F,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, "reserved_1f");
    drive(5'h17,   32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, "reserved_17");

    drive(OP_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, "slt");
    drive(OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, "sltu");
    drive(OP_EQ,   32'h1234, 32'h1234, 32'h1, 1'b0, "eq_true");
    drive(OP_EQ,   32'h1, 32'h2, 32'h0, 1'b0, "eq_false");
    drive(OP_MUL,  32'h00010000, 32'h00010000, 32'h0, 1'b1, "mul_overflow");
    drive(OP_MUL,  32'd3, 32'd5, 32'd15, 1'b0, "mul_small");
    drive(OP_PASSA, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 1'b0, "passa");
    drive(OP_PASSB, 32'h1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "passb");

    // back-to-back with no idle cycle in between
    idle();
    drive(OP_ADD,  32'd10, 32'd20, 32'd30, 1'b0, "b2b_add");
    drive(OP_SUB,  32'd1, 32'd2, 32'hFFFFFFFF, 1'b0, "b2b_sub");
    drive(OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, "b2b_xor");
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_design.md
# alu_design

32-bit combinational-datapath ALU with a registered result stage, selected by a 5-bit opcode. It is the design-side block behind the `alu` interface's `alu_design` modport: it consumes `A`, `B` and `opcode` and drives `out` and `carryout`. The bench-side `top` modport supplies the operands and checks the results.

## Interface
- No parameters; the width is fixed at 32.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `A`: input, 32 bits. Operand A.
- `B`: input, 32 bits. Operand B. For shifts and rotates, only `B[4:0]` is used as the amount.
- `opcode`: input, 5 bits. Operation select.
- `out`: output, 32 bits. Registered result.
- `carryout`: output, 1 bit. Registered carry or flag.

## Operation
Opcode map, hex. All arithmetic is modulo 2^32. `carryout` is 0 unless stated.
- 00 ADD: `{carryout,out} = A + B`.
- 01 SUB: `out = A - B`. `carryout` is the carry of `A + ~B + 1`, so it is 1 when A ≥ B unsigned.
- 02 INC: `{carryout,out} = A + 1`.
- 03 DEC: `out = A - 1`. `carryout = (A != 0)`.
- 04 AND, 05 OR, 06 XOR, 07 NAND, 08 NOR, 09 XNOR: bitwise operations on A and B.
- 0A NOT: `out = ~A`.
- 0B SLL, 0C SRL, 0D SRA:
  - A is shifted by `B[4:0]`.
  - `carryout` is the last bit shifted out.
  - `carryout` is 0 when the shift amount is 0.
- 0E ROL, 0F ROR: A is rotated by `B[4:0]`.
- 10 MUL:
  - `out` is the low 32 bits of the unsigned product A×B.
  - `carryout = 1` when the high 32 bits are nonzero.
- 11 SLT: `out = {31'b0, $signed(A) < $signed(B)}`.
- 12 SLTU: `out = {31'b0, A < B}`, unsigned compare.
- 13 EQ: `out = {31'b0, A == B}`.
- 14 PASSA: `out = A`.
- 15 PASSB: `out = B`.
- 16 NEG: `out = 0 - A`. `carryout = (A == 0)`.
- 17–1F: reserved. `out = 0`, `carryout = 0`. No error flag.

## Timing
- The result is computed combinationally and registered on `posedge clk`. Latency is 1 cycle.
- Inputs are sampled on every rising edge. There is no handshake and no valid signal; the block accepts a new operation every cycle.
- When `rst_n` goes low, `out` and `carryout` clear to 0 immediately, without waiting for a clock edge.
- While reset is held, the outputs stay 0.
- The first valid result appears on the first rising edge after `rst_n` deasserts.
- An opcode change takes effect at the next edge only. There is no intermediate state and no other state.

## Structure
- Package `alu_pkg`:
  - a `typedef enum logic [4:0] opcode_e` holding the mnemonics above;
  - the width constant `ALU_W = 32`.
- Sub-module `alu_shifter`:
  - combinational;
  - covers SLL, SRL, SRA, ROL and ROR with the carry-out rule;
  - inputs are A, the amount and the mode.
- The top level holds the opcode `case` statement plus the output register.

## Test plan
- Reset and ADD:
  - assert `rst_n=0` mid-run → `out=0`, `carryout=0` asynchronously;
  - release, then ADD with A=FFFFFFFF, B=00000001 → next edge gives `out=00000000`, `carryout=1`.
- SUB and NEG:
  - SUB with A=5, B=7 → `out=FFFFFFFE`, `carryout=0`;
  - SUB with A=7, B=5 → `out=2`, `carryout=1`;
  - NEG with A=0 → `out=0`, `carryout=1`.
- Shifts and rotates:
  - SLL with A=80000001, B=1 → `out=00000002`, `carryout=1`;
  - SRA with A=80000000, B=4 → `out=F8000000`, `carryout=0`;
  - ROR with A=1, B=1 → `out=80000000`.
- Logic and reserved opcodes:
  - AND/OR/XOR/NAND with A=F0F0F0F0, B=FF00FF00 → `out` = F000F000 / FFF0FFF0 / 0FF00FF0 / 0FFF0FFF;
  - opcode 1F → `out=0`, `carryout=0`.
- Compares and MUL:
  - SLT with A=FFFFFFFF, B=1 → `out=1`;
  - SLTU with the same operands → `out=0`;
  - EQ with equal operands → `out=1`;
  - MUL with A=00010000, B=00010000 → `out=0`, `carryout=1`.
- Back-to-back: ADD, SUB, XOR on consecutive cycles → each result appears exactly one cycle after its inputs, with no bubbles.
